// File: rtl/tqvp_rebeccargb_bin2bcd_if.sv
// Peripheral register bus for the bin2bcd block.
// Address/strobe/write data in, combinational read data out.
interface tqvp_rebeccargb_bin2bcd_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address, data_write, data_in,
        input  data_out
    );

    modport slave (
        input  address, data_write, data_in,
        output data_out
    );
endinterface

// File: rtl/tqvp_rebeccargb_bin2bcd.sv
// Binary to packed BCD converter, one double-dabble step per clock.
// Feeds a selected digit and its blanking flag to the digit decoder.
module tqvp_rebeccargb_bin2bcd #(
    parameter int BIN_W = 16,
    parameter int NDIG  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    tqvp_rebeccargb_bin2bcd_if.slave bus,
    output logic [3:0] digit_out,
    output logic       digit_blank,
    output logic       digit_valid
);
    localparam int RW = 4 * NDIG;
    localparam int SW = RW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t          state, state_d;
    logic [BIN_W-1:0] bin, bin_d;
    logic [RW-1:0]   res;
    logic [SW-1:0]   sh, sh_adj, sh_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      sel;
    logic            lzb, valid, busy;
    logic            start, done;
    logic            wr_lo, wr_hi, wr_ctl, wr_sel;
    logic [31:0]     res_x;

    wire unused_ui = &{1'b0, ui_in};

    always_comb begin
        wr_lo  = 1'b0;
        wr_hi  = 1'b0;
        wr_ctl = 1'b0;
        wr_sel = 1'b0;
        if (bus.data_write) begin
            unique case (bus.address)
                4'h0:    wr_lo  = 1'b1;
                4'h1:    wr_hi  = 1'b1;
                4'h2:    wr_ctl = 1'b1;
                4'h3:    wr_sel = 1'b1;
                default: ;
            endcase
        end
    end

    assign start = wr_hi | (wr_ctl & bus.data_in[0]);

    // START must see the byte written in the same cycle
    always_comb begin
        bin_d = bin;
        if (wr_lo)
            bin_d[7:0] = bus.data_in;
        if (wr_hi)
            bin_d[BIN_W-1:8] = bus.data_in[BIN_W-9:0];
    end

    // Nibble adds wrap at 4 bits; no carry between digits
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < NDIG; i++) begin
            if (sh[BIN_W+4*i +: 4] >= 4'd5)
                sh_adj[BIN_W+4*i +: 4] = sh[BIN_W+4*i +: 4] + 4'd3;
        end
        sh_nx = {sh_adj[SW-2:0], 1'b0};
    end

    always_comb begin
        state_d = state;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start)
                    state_d = ST_CONV;
            end
            ST_CONV: begin
                if (start)
                    state_d = ST_CONV;
                else if (cnt == CW'(1)) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_CONV);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin   <= '0;
            res   <= '0;
            sh    <= '0;
            cnt   <= '0;
            sel   <= '0;
            lzb   <= 1'b0;
            valid <= 1'b0;
        end else begin
            bin <= bin_d;
            if (wr_ctl)
                lzb <= bus.data_in[1];
            if (wr_sel)
                sel <= bus.data_in[2:0];
            if (start) begin
                sh  <= SW'(bin_d);
                cnt <= CW'(BIN_W);
            end else if (busy) begin
                sh  <= sh_nx;
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                res   <= sh_nx[SW-1:BIN_W];
                valid <= 1'b1;
            end
        end
    end

    assign res_x = 32'(res);

    // Blank only when this digit and everything above it are zero
    always_comb begin
        digit_out   = 4'd0;
        digit_blank = 1'b1;
        if (sel < 3'(NDIG)) begin
            digit_out   = res_x[{sel, 2'b00} +: 4];
            digit_blank = lzb & valid & (sel != 3'd0) &
                          ((res_x >> {sel, 2'b00}) == 32'd0);
        end
    end

    assign digit_valid = valid & ~busy;
    assign uo_out = {busy, valid, digit_blank, 1'b0, digit_out};

    always_comb begin
        unique case (bus.address)
            4'h0:    bus.data_out = res_x[7:0];
            4'h1:    bus.data_out = res_x[15:8];
            4'h2:    bus.data_out = {busy, valid, lzb, 1'b0, res_x[19:16]};
            4'h3:    bus.data_out = {digit_blank, 3'b000, digit_out};
            default: bus.data_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_tqvp_rebeccargb_bin2bcd.sv
// Bench for the bin2bcd peripheral: directed cases plus random
// values checked against an arithmetic decimal-digit model.
module tb_tqvp_rebeccargb_bin2bcd;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] digit_out;
    logic       digit_blank;
    logic       digit_valid;

    tqvp_rebeccargb_bin2bcd_if bus ();

    tqvp_rebeccargb_bin2bcd dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ui_in       (ui_in),
        .uo_out      (uo_out),
        .bus         (bus.slave),
        .digit_out   (digit_out),
        .digit_blank (digit_blank),
        .digit_valid (digit_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++)
            p *= 10;
        return p;
    endfunction

    function automatic logic [3:0] ref_digit(input int v, input int k);
        if (k > 4)
            return 4'd0;
        return 4'((v / pow10(k)) % 10);
    endfunction

    function automatic logic ref_blank(input int v, input logic lzb,
                                       input int s);
        if (s >= 5)
            return 1'b1;
        return lzb && (s != 0) && (v < pow10(s));
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (uo_out[7] && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic conv(input logic [15:0] v, input string tag);
        int n;
        wr(4'h0, v[7:0]);
        wr(4'h1, v[15:8]);
        wait_done(n);
        check({tag, "_busy_cycles"}, n, 16);
    endtask

    initial begin
        logic [7:0] d;
        int         n;
        int         v;
        int         s;
        logic       lz;

        bus.address    = 4'h0;
        bus.data_in    = 8'h00;
        bus.data_write = 1'b0;
        ui_in          = 8'($urandom);
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_uo", uo_out, 8'h00);
        rd(4'h0, d);
        check("rst_a0", d, 8'h00);
        check("rst_digit", digit_out, 4'd0);
        check("rst_blank", digit_blank, 1'b0);
        check("rst_dvalid", digit_valid, 1'b0);

        conv(16'h1234, "t1");
        rd(4'h0, d);
        check("t1_a0", d, 8'h60);
        rd(4'h1, d);
        check("t1_a1", d, 8'h46);
        rd(4'h2, d);
        check("t1_a2", d, 8'h40);
        check("t1_dvalid", digit_valid, 1'b1);

        conv(16'hFFFF, "t2");
        rd(4'h0, d);
        check("t2_a0", d, 8'h35);
        rd(4'h1, d);
        check("t2_a1", d, 8'h55);
        rd(4'h2, d);
        check("t2_a2", d, 8'h46);

        // restart mid-conversion keeps the old result until done
        wr(4'h0, 8'h01);
        wr(4'h1, 8'h00);
        repeat (4) @(negedge clk);
        check("t4_dvalid_busy", digit_valid, 1'b0);
        rd(4'h0, d);
        check("t4_res_hold", d, 8'h35);
        wr(4'h0, 8'h09);
        check("t4_still_busy", uo_out[7], 1'b1);
        wr(4'h1, 8'h00);
        wait_done(n);
        check("t4_busy_cycles", n, 16);
        rd(4'h0, d);
        check("t4_a0", d, 8'h09);
        rd(4'h1, d);
        check("t4_a1", d, 8'h00);

        wr(4'h2, 8'h02);
        conv(16'h0000, "t3");
        wr(4'h3, 8'h03);
        check("t3_sel3_blank", digit_blank, 1'b1);
        wr(4'h3, 8'h00);
        check("t3_sel0_digit", digit_out, 4'd0);
        check("t3_sel0_blank", digit_blank, 1'b0);

        conv(16'h3039, "t6");
        wr(4'h3, 8'h02);
        check("t6_digit", digit_out, 4'd3);
        check("t6_uo", uo_out, 8'h43);
        wr(4'h3, 8'h05);
        check("t6_sel5_digit", digit_out, 4'd0);
        check("t6_sel5_blank", digit_blank, 1'b1);

        // reset in busy cycle 8
        wr(4'h0, 8'hA5);
        wr(4'h1, 8'h5A);
        repeat (7) @(negedge clk);
        check("t5_busy_pre", uo_out[7], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_uo", uo_out, 8'h00);
        rd(4'h0, d);
        check("t5_a0", d, 8'h00);
        rd(4'h2, d);
        check("t5_a2", d, 8'h00);
        check("t5_dvalid", digit_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            v  = int'($urandom_range(0, 65535));
            s  = int'($urandom_range(0, 7));
            lz = 1'($urandom);
            wr(4'h2, {6'd0, lz, 1'b0});
            wr(4'h3, 8'(s));
            conv(16'(v), "rnd");
            rd(4'h0, d);
            check("rnd_a0", d, {ref_digit(v, 1), ref_digit(v, 0)});
            rd(4'h1, d);
            check("rnd_a1", d, {ref_digit(v, 3), ref_digit(v, 2)});
            rd(4'h2, d);
            check("rnd_a2", d, {3'b010, 1'b0, ref_digit(v, 4)} | {2'b00, lz, 5'd0});
            check("rnd_digit", digit_out, ref_digit(v, s));
            check("rnd_blank", digit_blank, ref_blank(v, lz, s));
            check("rnd_dvalid", digit_valid, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
